lspc_timing: RTL
================

# lspc_timing

Video raster timing generator for the MVS board model; it stands in for the LSPC timing slice. From `CLK_24M` it derives the 6 MHz pixel enable, horizontal and vertical counters, composite sync, the active-low blanking strobe `nBNKB`, and the vertical-blank interrupt that the 68k core consumes. It sits directly upstream of the board-level colour latch and blanking stage, which samples `nBNKB` and drives `VIDEO_SYNC` from this block.

## Interface
Parameters:
- `H_TOTAL`, 384: pixels per line.
- `H_ACTIVE`, 320: visible pixels, at H = 0 to H_ACTIVE-1.
- `H_SYNC_START`, 336: first H with hsync asserted.
- `H_SYNC_LEN`, 29: hsync width in pixels.
- `V_TOTAL`, 264: lines per frame.
- `V_ACTIVE_START`, 16: first visible line.
- `V_ACTIVE`, 224: number of visible lines.
- `V_SYNC_START`, 248: first vsync line.
- `V_SYNC_LEN`, 8: vsync width in lines.

Ports:
- `CLK_24M`  in  1  master clock.
- `RESET`  in  1  reset, asynchronous, active-high.
- `PIXEL_CE`  out  1  one-cycle pixel enable, asserted 1 of every 4 clocks.
- `H_CNT`  out  9  current pixel, 0 to H_TOTAL-1.
- `V_CNT`  out  9  current line, 0 to V_TOTAL-1.
- `nBNKB`  out  1  low outside the active window.
- `VIDEO_SYNC`  out  1  composite sync, active-low.
- `IRQ_ACK`  in  2  one-cycle acknowledge pulses; bit0 = VBL, bit1 = raster.
- `IRQ`  out  2  level interrupt requests; bit0 = VBL, bit1 = raster.
- `IRQ_LINE`  in  9  raster compare line. Only present with `LSPC_TIMING_RASTER_IRQ_EN`.

## Operation
Pixel divider:
- 2-bit `DIV` counts 0 to 3 and wraps.
- `PIXEL_CE` is high in the cycle where `DIV` = 3.

Counters:
- Both counters advance only on `PIXEL_CE`.
- `H_CNT` wraps from H_TOTAL-1 to 0.
- On that H wrap, `V_CNT` increments, wrapping from V_TOTAL-1 to 0.

Decode:
- `active` = (H < H_ACTIVE) && (V_ACTIVE_START ≤ V < V_ACTIVE_START + V_ACTIVE).
- `nBNKB` = `active`.
- `hs` = H in [H_SYNC_START, H_SYNC_START + H_SYNC_LEN).
- `vs` = V in [V_SYNC_START, V_SYNC_START + V_SYNC_LEN).
- `VIDEO_SYNC` = ~(hs ^ vs), giving serrated vsync.
- All range compares use 10-bit arithmetic so that start + len cannot overflow.

VBL interrupt:
- `IRQ[0]` sets on the `PIXEL_CE` that moves the counters to H = 0, V = V_ACTIVE_START + V_ACTIVE.
- It stays set until `IRQ_ACK[0]`.
- If set and ack occur in the same cycle, set wins.
- Ack while the flag is clear has no effect.

Reset:
- `DIV`, `H_CNT` and `V_CNT` reset to 0, with `PIXEL_CE` = 0.
- `nBNKB` = 0, `VIDEO_SYNC` = 1, `IRQ` = 0.
- A reset mid-frame restarts the frame at (0, 0) on the first clock after release. Any pending IRQ is lost.

## Timing
- The counters update on the `CLK_24M` edge where `PIXEL_CE` is high.
- `nBNKB`, `VIDEO_SYNC` and `IRQ` are registered from the updated counters and change 1 clock later. They then hold stable for the remaining 3 clocks of that pixel.
- The colour latch samples within that window.
- Frame length is 384 × 264 × 4 = 405504 clocks.
- `IRQ` latency from the trigger pixel edge is 1 clock.
- The earliest `IRQ` deassertion is 1 clock after the ack edge.

## Configuration
`LSPC_TIMING_RASTER_IRQ_EN`
- **Defined:** the `IRQ_LINE` port exists. `IRQ[1]` sets on the `PIXEL_CE` that moves the counters to H = 0 with V = `IRQ_LINE`, using `IRQ_LINE` as sampled at that edge. It clears on `IRQ_ACK[1]`, with set winning over a simultaneous ack. An `IRQ_LINE` of V_TOTAL or more never fires.
- **Undefined:** `IRQ_LINE` is absent, `IRQ[1]` is tied to 0, and `IRQ_ACK[1]` is ignored.

## Structure
- Package `lspc_pkg` holds:
  - default timing constants (384/320/336/29/264/16/224/248/8);
  - the 9-bit counter typedef;
  - IRQ bit index constants.
- One sub-module, `lspc_irq_flag`: set/ack/clear flip-flop with set priority. It is instantiated once per IRQ bit.
- Divider, counters and decode stay in the top module.

## Test plan
- **Reset:** assert `RESET` mid-line at H = 200 → outputs take reset values immediately. After release, `PIXEL_CE` first fires on clock 4 and H = 1.
- **Line timing:** run 1 line → `VIDEO_SYNC` is low for exactly 29 × 4 = 116 clocks starting at H = 336; `nBNKB` is high for 320 pixels on line 16.
- **Frame:** run 405504 clocks → V returns to 0. `nBNKB` is never high on lines 0–15 or 240–263. Sync is inverted (serrated) on lines 248–255.
- **VBL IRQ:** `IRQ[0]` rises 1 clock after (0, 240). Ack in the same cycle as a new set → the flag stays set. An ack 10 clocks later → the flag clears.
- **Raster IRQ** (macro on): `IRQ_LINE` = 100 → `IRQ[1]` at (0, 100) only. `IRQ_LINE` = 300 → never fires. With the macro off, `IRQ[1]` stays 0 for a whole frame.

Source files
------------

// File: rtl/lspc_pkg.sv
// Shared timing defaults, counter type and IRQ bit map for the LSPC raster
// timing slice.
package lspc_pkg;

  localparam int LSPC_H_TOTAL        = 384;
  localparam int LSPC_H_ACTIVE       = 320;
  localparam int LSPC_H_SYNC_START   = 336;
  localparam int LSPC_H_SYNC_LEN     = 29;
  localparam int LSPC_V_TOTAL        = 264;
  localparam int LSPC_V_ACTIVE_START = 16;
  localparam int LSPC_V_ACTIVE       = 224;
  localparam int LSPC_V_SYNC_START   = 248;
  localparam int LSPC_V_SYNC_LEN     = 8;

  typedef logic [8:0] lspc_cnt_t;

  localparam int IRQ_VBL    = 0;
  localparam int IRQ_RASTER = 1;
  localparam int IRQ_NUM    = 2;

  // Half-open window test; widened to 10 bits so start + len cannot wrap.
  function automatic logic in_window(input logic [9:0] val,
                                     input logic [9:0] start,
                                     input logic [9:0] len);
    return (val >= start) && (val < start + len);
  endfunction

endpackage

// File: rtl/lspc_irq_flag.sv
// Level interrupt request flag: set pulse raises it, ack pulse clears it,
// and a set coinciding with an ack wins.
module lspc_irq_flag (
  input  logic CLK_24M,
  input  logic RESET,
  input  logic set,
  input  logic ack,
  output logic flag
);

  logic flag_reg;

  always_ff @(posedge CLK_24M or posedge RESET) begin
    if (RESET) begin
      flag_reg <= 1'b0;
    end else if (set) begin
      flag_reg <= 1'b1;
    end else if (ack) begin
      flag_reg <= 1'b0;
    end
  end

  assign flag = flag_reg;

endmodule

// File: rtl/lspc_timing.sv
// LSPC raster timing: pixel divider, H/V counters, blanking/sync decode and
// VBL/raster IRQ flags. Raster IRQ is built only with LSPC_TIMING_RASTER_IRQ_EN.
module lspc_timing
  import lspc_pkg::*;
#(
  parameter int H_TOTAL        = LSPC_H_TOTAL,
  parameter int H_ACTIVE       = LSPC_H_ACTIVE,
  parameter int H_SYNC_START   = LSPC_H_SYNC_START,
  parameter int H_SYNC_LEN     = LSPC_H_SYNC_LEN,
  parameter int V_TOTAL        = LSPC_V_TOTAL,
  parameter int V_ACTIVE_START = LSPC_V_ACTIVE_START,
  parameter int V_ACTIVE       = LSPC_V_ACTIVE,
  parameter int V_SYNC_START   = LSPC_V_SYNC_START,
  parameter int V_SYNC_LEN     = LSPC_V_SYNC_LEN
) (
  input  logic       CLK_24M,
  input  logic       RESET,
  output logic       PIXEL_CE,
  output logic [8:0] H_CNT,
  output logic [8:0] V_CNT,
  output logic       nBNKB,
  output logic       VIDEO_SYNC,
  input  logic [1:0] IRQ_ACK,
  output logic [1:0] IRQ
`ifdef LSPC_TIMING_RASTER_IRQ_EN
  ,
  input  logic [8:0] IRQ_LINE
`endif
);

  localparam lspc_cnt_t  H_LAST   = lspc_cnt_t'(H_TOTAL - 1);
  localparam lspc_cnt_t  V_LAST   = lspc_cnt_t'(V_TOTAL - 1);
  localparam lspc_cnt_t  VBL_LINE = lspc_cnt_t'(V_ACTIVE_START + V_ACTIVE);
  localparam logic [9:0] HA_W     = 10'(H_ACTIVE);
  localparam logic [9:0] HSS_W    = 10'(H_SYNC_START);
  localparam logic [9:0] HSL_W    = 10'(H_SYNC_LEN);
  localparam logic [9:0] VAS_W    = 10'(V_ACTIVE_START);
  localparam logic [9:0] VA_W     = 10'(V_ACTIVE);
  localparam logic [9:0] VSS_W    = 10'(V_SYNC_START);
  localparam logic [9:0] VSL_W    = 10'(V_SYNC_LEN);

  logic [1:0]         div_reg;
  lspc_cnt_t          h_reg;
  lspc_cnt_t          v_reg;
  lspc_cnt_t          h_next;
  lspc_cnt_t          v_next;
  logic               line_end;
  logic [9:0]         h_ext;
  logic [9:0]         v_ext;
  logic               active;
  logic               hs;
  logic               vs;
  logic               nbnkb_reg;
  logic               sync_reg;
  logic [IRQ_NUM-1:0] irq_set_reg;
  logic [IRQ_NUM-1:0] irq_set_next;

  assign PIXEL_CE = (div_reg == 2'd3);
  assign line_end = (h_reg == H_LAST);

  always_comb begin
    h_next = line_end ? '0 : h_reg + 9'd1;
    v_next = v_reg;
    if (line_end) begin
      v_next = (v_reg == V_LAST) ? '0 : v_reg + 9'd1;
    end
  end

  assign h_ext  = {1'b0, h_reg};
  assign v_ext  = {1'b0, v_reg};
  assign active = (h_ext < HA_W) && in_window(v_ext, VAS_W, VA_W);
  assign hs     = in_window(h_ext, HSS_W, HSL_W);
  assign vs     = in_window(v_ext, VSS_W, VSL_W);

  // Trigger is detected on the counter-advance edge, so the flag follows
  // one clock later, aligned with the registered blank/sync outputs.
  always_comb begin
    irq_set_next          = '0;
    irq_set_next[IRQ_VBL] = PIXEL_CE && line_end && (v_next == VBL_LINE);
`ifdef LSPC_TIMING_RASTER_IRQ_EN
    irq_set_next[IRQ_RASTER] = PIXEL_CE && line_end && (v_next == IRQ_LINE);
`endif
  end

  always_ff @(posedge CLK_24M or posedge RESET) begin
    if (RESET) begin
      div_reg     <= 2'd0;
      h_reg       <= '0;
      v_reg       <= '0;
      nbnkb_reg   <= 1'b0;
      sync_reg    <= 1'b1;
      irq_set_reg <= '0;
    end else begin
      div_reg <= div_reg + 2'd1;
      if (PIXEL_CE) begin
        h_reg <= h_next;
        v_reg <= v_next;
      end
      nbnkb_reg   <= active;
      sync_reg    <= ~(hs ^ vs);
      irq_set_reg <= irq_set_next;
    end
  end

  // Without the raster option bit 1's set input is constant low, so IRQ[1]
  // holds its reset value of 0 and its ack has nothing to clear.
  genvar gi;
  generate
    for (gi = 0; gi < IRQ_NUM; gi++) begin : g_irq
      lspc_irq_flag u_flag (
        .CLK_24M (CLK_24M),
        .RESET   (RESET),
        .set     (irq_set_reg[gi]),
        .ack     (IRQ_ACK[gi]),
        .flag    (IRQ[gi])
      );
    end
  endgenerate

  assign H_CNT      = h_reg;
  assign V_CNT      = v_reg;
  assign nBNKB      = nbnkb_reg;
  assign VIDEO_SYNC = sync_reg;

endmodule
